// File: rtl/score_bcd_converter.sv
// score_bcd_converter
//   Sequential double-dabble converter: turns a BIN_W-bit unsigned score into
//   DIGITS packed BCD digits, one input bit per clock. It uses a start/busy/done
//   handshake and also produces per-digit leading-zero blanking and an
//   overflow flag.
//   Optional build macro SCORE_BCD_AUTO_REFRESH_EN: when it is defined, a new
//   conversion also starts whenever bin_in differs from the last converted
//   value.
`timescale 1ns/1ps

module score_bcd_converter #(
   parameter int BIN_W  = 21,
   parameter int DIGITS = 7
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  overflow
);

   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [BIN_W-1:0]     bin_sr;
   logic [4*DIGITS-1:0]  scratch;
   logic                 ovf_scratch;
   logic [CNT_W-1:0]     cnt;

   logic                 accept;
   logic                 last_shift;
   logic [4*DIGITS-1:0]  corrected;
   logic [4*DIGITS-1:0]  scratch_shifted;
   logic                 carry_out;
   logic [DIGITS-1:0]    valid_next;
   logic                 nz_seen;

`ifdef SCORE_BCD_AUTO_REFRESH_EN
   logic [BIN_W-1:0]     last_bin;

   assign accept = (state == IDLE) && (start || (bin_in != last_bin));

   // Remember the value of each accepted conversion so an unchanged score does not retrigger.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)       last_bin <= '0;
      else if (accept) last_bin <= bin_in;
   end
`else
   assign accept = (state == IDLE) && start;
`endif

   assign last_shift = (cnt == CNT_W'(1));
   assign busy       = (state == SHIFT) || (state == DONE);
   assign done       = (state == DONE);

   // Add-3 correction on every digit >= 5, followed by the one-bit left shift of {scratch, bin}.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      corrected = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      {carry_out, scratch_shifted} = {corrected, bin_sr[BIN_W-1]};
   end

   // A digit is significant if it or any higher digit is nonzero. The ones digit always is.
   always_comb begin
      valid_next = '0;
      nz_seen    = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nz_seen       = nz_seen | (scratch_shifted[4*i +: 4] != 4'd0);
         valid_next[i] = nz_seen;
      end
      valid_next[0] = 1'b1;
   end

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: IDLE -> SHIFT on an accepted start, SHIFT -> DONE after BIN_W shifts, DONE -> IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)     state_next = SHIFT;
         SHIFT:   if (last_shift) state_next = DONE;
         DONE:                    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // Conversion datapath. The results are written on the final shift so they appear together with done.
   always_ff @(posedge Clk or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         bin_sr      <= '0;
         scratch     <= '0;
         ovf_scratch <= 1'b0;
         cnt         <= '0;
         bcd_out     <= '0;
         digit_valid <= DIGITS'(1);
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bin_sr      <= bin_in;
                  scratch     <= '0;
                  ovf_scratch <= 1'b0;
                  cnt         <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               scratch     <= scratch_shifted;
               bin_sr      <= {bin_sr[BIN_W-2:0], 1'b0};
               ovf_scratch <= ovf_scratch | carry_out;
               cnt         <= cnt - CNT_W'(1);
               if (last_shift) begin
                  bcd_out     <= scratch_shifted;
                  digit_valid <= valid_next;
                  overflow    <= ovf_scratch | carry_out;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
